// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: opcode/ALU constants, field positions and FSM states for the hazard controller
package hazard_stall_ctrl_pkg;
   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] ALU_MULT = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;
   localparam int OP_LSB  = 27;
   localparam int RD_LSB  = 22;
   localparam int RS_LSB  = 17;
   localparam int RT_LSB  = 12;
   localparam int ALU_LSB = 2;
   typedef logic [1:0] md_state_t;
   localparam md_state_t ST_IDLE = 2'd0;
   localparam md_state_t ST_BUSY = 2'd1;
   localparam md_state_t ST_WB   = 2'd2;
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: decode/execute hazard bus; perf outputs exist only with HAZARD_PERF_CNT_EN
interface hazard_stall_ctrl_if #(parameter int INSN_W = 32, parameter int REG_W = 5);
   logic [INSN_W-1:0] fd_insn, dx_insn;
   logic              fd_valid, dx_valid, md_ready;
   logic              stall, dx_bubble, md_busy, md_error;
   logic [REG_W-1:0]  md_pend_rd;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0]       perf_ld_stalls, perf_md_stalls, perf_md_ops;
   modport master(output fd_insn, fd_valid, dx_insn, dx_valid, md_ready,
                  input stall, dx_bubble, md_busy, md_pend_rd, md_error,
                  perf_ld_stalls, perf_md_stalls, perf_md_ops);
   modport slave(input fd_insn, fd_valid, dx_insn, dx_valid, md_ready,
                 output stall, dx_bubble, md_busy, md_pend_rd, md_error,
                 perf_ld_stalls, perf_md_stalls, perf_md_ops);
`else
   modport master(output fd_insn, fd_valid, dx_insn, dx_valid, md_ready,
                  input stall, dx_bubble, md_busy, md_pend_rd, md_error);
   modport slave(input fd_insn, fd_valid, dx_insn, dx_valid, md_ready,
                 output stall, dx_bubble, md_busy, md_pend_rd, md_error);
`endif
endinterface

// File: rtl/hazard_stall_ctrl_insn_hazard_decode.sv
// insn_hazard_decode: extracts register fields and read/write/class flags from one instruction
module insn_hazard_decode #(parameter int INSN_W = 32, parameter int REG_W = 5) (
   input  logic [INSN_W-1:0] insn_i,
   output logic [REG_W-1:0]  rs_o, rt_o, rd_o,
   output logic              reads_rs_o, reads_rt_o, writes_rd_o, is_lw_o, is_md_o
);
   import hazard_stall_ctrl_pkg::*;
   logic [4:0] op, alu;
   logic       is_r;
   logic       unused_bits;
   assign op          = insn_i[OP_LSB +: 5];
   assign alu         = insn_i[ALU_LSB +: 5];
   assign is_r        = op == OP_RTYPE;
   assign rs_o        = insn_i[RS_LSB +: REG_W];
   assign rt_o        = insn_i[RT_LSB +: REG_W];
   assign rd_o        = insn_i[RD_LSB +: REG_W];
   assign reads_rs_o  = 1'b1;
   assign reads_rt_o  = is_r;
   assign is_lw_o     = op == OP_LW;
   assign writes_rd_o = is_r | is_lw_o;
   assign is_md_o     = is_r & (alu == ALU_MULT | alu == ALU_DIV);
   assign unused_bits = ^insn_i;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use and multdiv stall control; HAZARD_PERF_CNT_EN adds stall/issue counters
module hazard_stall_ctrl #(
   parameter int INSN_W     = 32,
   parameter int REG_W      = 5,
   parameter int MD_MODE    = 1,
   parameter int MD_TIMEOUT = 64
) (
   input logic                clock_i,
   input logic                reset_i,
   hazard_stall_ctrl_if.slave bus
);
   import hazard_stall_ctrl_pkg::*;
   localparam int CW = $clog2(MD_TIMEOUT + 1);
   logic [REG_W-1:0] fd_rs, fd_rt, fd_rd, dx_rd, dx_unused_rs, dx_unused_rt;
   logic fd_rd_rs, fd_rd_rt, fd_wr, fd_md, fd_unused_lw;
   logic dx_unused_rdrs, dx_unused_rdrt, dx_unused_wr, dx_lw, dx_md;
   md_state_t        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [REG_W-1:0] pend_q, pend_d, chk_rd;
   logic             err_q, err_d, busy, issue, active, dep, lu, md_stall;
   insn_hazard_decode #(.INSN_W(INSN_W), .REG_W(REG_W)) u_fd (
      .insn_i(bus.fd_insn), .rs_o(fd_rs), .rt_o(fd_rt), .rd_o(fd_rd),
      .reads_rs_o(fd_rd_rs), .reads_rt_o(fd_rd_rt), .writes_rd_o(fd_wr),
      .is_lw_o(fd_unused_lw), .is_md_o(fd_md));
   insn_hazard_decode #(.INSN_W(INSN_W), .REG_W(REG_W)) u_dx (
      .insn_i(bus.dx_insn), .rs_o(dx_unused_rs), .rt_o(dx_unused_rt), .rd_o(dx_rd),
      .reads_rs_o(dx_unused_rdrs), .reads_rt_o(dx_unused_rdrt), .writes_rd_o(dx_unused_wr),
      .is_lw_o(dx_lw), .is_md_o(dx_md));
   assign busy   = state_q == ST_BUSY;
   assign issue  = bus.dx_valid & dx_md & (state_q == ST_IDLE | state_q == ST_WB);
   assign active = busy | issue;
   // while busy the pending rd is the hazard target; on the issue cycle it is still in D/X
   assign chk_rd = busy ? pend_q : dx_rd;
   assign dep    = chk_rd != '0 & ((fd_rd_rs & fd_rs == chk_rd) | (fd_rd_rt & fd_rt == chk_rd)
                                   | (fd_wr & fd_rd == chk_rd));
   assign md_stall = bus.fd_valid & active & ((MD_MODE == 0) | dep | fd_md);
   assign lu     = bus.dx_valid & bus.fd_valid & dx_lw & dx_rd != '0
                   & ((fd_rd_rs & fd_rs == dx_rd) | (fd_rd_rt & fd_rt == dx_rd));
   assign bus.stall      = ~reset_i & (lu | md_stall);
   assign bus.dx_bubble  = bus.stall;
   assign bus.md_busy    = ~reset_i & state_q != ST_IDLE;
   assign bus.md_pend_rd = pend_q;
   assign bus.md_error   = err_q;
   // multdiv scoreboard: md_ready beats the timeout; WB can accept a back-to-back issue
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      err_d   = err_q;
      if (busy) begin
         cnt_d = cnt_q + 1'b1;
         if (bus.md_ready) state_d = ST_WB;
         else if (cnt_q == CW'(MD_TIMEOUT - 1)) begin
            state_d = ST_IDLE;
            pend_d  = '0;
            err_d   = 1'b1;
         end
      end else if (issue) begin
         state_d = ST_BUSY;
         cnt_d   = '0;
         pend_d  = dx_rd;
      end else if (state_q == ST_WB) begin
         state_d = ST_IDLE;
         pend_d  = '0;
      end
   end
   // FSM state registers; reset abandons any op without flagging an error
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] ld_q, mds_q, ops_q;
   assign bus.perf_ld_stalls = ld_q;
   assign bus.perf_md_stalls = mds_q;
   assign bus.perf_md_ops    = ops_q;
   // saturating event counters; a cycle with both stall causes bumps both
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         ld_q  <= '0;
         mds_q <= '0;
         ops_q <= '0;
      end else begin
         ld_q  <= ld_q + 32'(lu && ld_q != '1);
         mds_q <= mds_q + 32'(md_stall && mds_q != '1);
         ops_q <= ops_q + 32'(issue && ops_q != '1);
      end
   end
`endif
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Next-generation stall/hazard controller for the 5-stage pipeline. Sits between decode (F/D latch) and execute (D/X latch); drives the pipeline stall and the D/X bubble.
- Adds the following over the earlier purely combinational unit:
  - registered multdiv scoreboard FSM with a timeout;
  - exemption for register $0;
  - parametrised field layout;
  - selectable stall policy (stall-all legacy mode, or dependency-only scoreboard mode).

Parameters:
- INSN_W, 32, instruction width.
- REG_W, 5, register-address width; register 0 is hardwired zero.
- MD_MODE, 1, 0 = stall every F/D instruction while multdiv is busy (legacy); 1 = stall only on dependency.
- MD_TIMEOUT, 64, cycles in MD_BUSY before abort; counter width = $clog2(MD_TIMEOUT+1).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- fd_insn  in  INSN_W  instruction in F/D latch
- fd_valid  in  1  F/D holds a real instruction
- dx_insn  in  INSN_W  instruction in D/X latch
- dx_valid  in  1  D/X holds a real instruction
- md_ready  in  1  one-cycle pulse from multdiv: result valid this cycle
- stall  out  1  hold PC and F/D this cycle
- dx_bubble  out  1  load nop into D/X next edge (equals stall)
- md_busy  out  1  FSM not IDLE
- md_pend_rd  out  REG_W  destination of the in-flight multdiv (0 when idle)
- md_error  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- Field layout:
  - opcode [31:27]; rd [26:22]; rs [21:17]; rt [16:12]; ALU op [6:2].
  - R-type = opcode 00000; lw = 01000; sw = 00111.
  - mult = R-type with ALU op 00110; div = R-type with ALU op 00111.
- Register reads of F/D:
  - rs is always a read.
  - rt is a read for R-type.
  - For sw, rt is not a read.
  - Reads of reg 0 never create a hazard.
- Load-use hazard (combinational):
  - Condition: dx_valid & fd_valid & dx is lw & dx.rd != 0 & F/D reads dx.rd.
- Multdiv issue: dx_valid & dx is mult/div while the FSM is in IDLE (or in WB, see below).
- FSM states (registered): IDLE, MD_BUSY, MD_WB.
  - IDLE -> MD_BUSY on issue; latch md_pend_rd <= dx.rd; tmo_cnt <= 0.
  - MD_BUSY:
    - tmo_cnt increments each cycle.
    - md_ready -> MD_WB.
    - If tmo_cnt == MD_TIMEOUT-1 and md_ready is not seen: -> IDLE, md_error <= 1, md_pend_rd <= 0.
  - MD_WB: one cycle, in which the result is written back.
    - If a new issue occurs this cycle -> MD_BUSY with the new rd latched.
    - Otherwise -> IDLE with md_pend_rd <= 0.
  - md_ready while in IDLE or MD_WB is ignored.
  - md_ready on the same edge as the timeout: md_ready wins (-> MD_WB, no error).
- Multdiv stall (combinational from state + F/D):
  - MD_MODE=0:
    - Stall when fd_valid and (the FSM is in MD_BUSY, or a multdiv is issuing this cycle).
  - MD_MODE=1: stall when fd_valid and any of the following holds in MD_BUSY or on the issue cycle:
    - F/D reads pend_rd (or dx.rd on the issue cycle), that register != 0;
    - F/D writes the same nonzero rd (WAW; applies to R-type and lw);
    - F/D is itself a mult/div.
  - MD_WB never stalls; the result is forwarded or written back.
- Outputs:
  - stall = load-use | multdiv stall.
  - dx_bubble = stall.
  - During a stall D/X is bubbled, so an lw stalls F/D for exactly 1 cycle.
- Reset:
  - Synchronous: state IDLE, tmo_cnt 0, md_pend_rd 0, md_error 0.
  - While reset is high, stall and dx_bubble are forced 0 and md_busy reads 0.
  - Reset mid-multdiv abandons the operation silently; no error is flagged.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds three outputs, each 32 bits, saturating at all-ones, cleared by reset:
  - perf_ld_stalls: cycles stalled by load-use;
  - perf_md_stalls: cycles stalled by multdiv;
  - perf_md_ops: multdiv issues.
- If load-use and multdiv stall in the same cycle, both counters increment.
- When undefined, these ports and registers are absent and stall behaviour is identical.

Decomposition:
- Shared package holds:
  - opcode and ALU-op constants (OP_RTYPE, OP_LW, OP_SW, ALU_MULT, ALU_DIV);
  - field bit positions;
  - the FSM state enum.
- One natural sub-module: insn_hazard_decode (pure combinational).
  - Maps an instruction to rs, rt, rd, reads_rs, reads_rt, writes_rd, is_lw, is_md.
  - Instantiated twice, once for F/D and once for D/X.

Test Plan:
- Load-use: dx=0x40C00000 (lw $3), fd=0x01065000 (add $4,$3,$5) -> stall=1 for exactly 1 cycle; same with dx=0x40000000 (lw $0) -> stall=0.
- sw exemption: dx=0x40C00000 (lw $3), fd=0x38003000 (sw, rt=$3, rs=$0) -> stall=0.
- Scoreboard (MD_MODE=1): dx=0x01822018 (mult $6,$1,$2).
  - Next cycle md_busy=1, md_pend_rd=6.
  - Independent fd 0x01065000 -> stall=0.
  - fd reading $6 (rs=6, 0x010C5000) -> stall=1 until md_ready; MD_WB next cycle with stall=0; then IDLE.
- Legacy mode (MD_MODE=0): same mult -> stall=1 from issue cycle until md_ready; 0 in MD_WB.
- Timeout (MD_TIMEOUT=8): issue mult, hold md_ready=0 -> after 8 busy cycles state IDLE, md_error=1 and sticky, stall drops; md_ready on cycle 8 instead -> no error.
- Reset mid-op: assert reset in MD_BUSY -> next edge md_busy=0, md_pend_rd=0, md_error=0, stall=0 while reset is high; with HAZARD_PERF_CNT_EN defined, all counters read 0.
